// File: rtl/pipeline_ifid_if.sv
// IF/ID boundary bus: fetch-side inputs, EX/ID hazard and redirect inputs, and registered ID outputs.
// Signal names match the pipeline-wide naming so the stage drops straight into the datapath.
interface pipeline_ifid_if;
    logic [31:0] IF_PC;
    logic [31:0] IF_Inst;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        EX_BranchTaken;
    logic        ID_Jump;
    logic        IRQ;
    logic [31:0] ID_PC;
    logic [31:0] ID_Inst;
    logic        ID_Valid;
    logic        stall;
    logic        EX_Bubble;
    logic        IRQ_Take;
    logic [31:0] ID_EPC;

    // The stage itself sits on the slave side; fetch/decode/EX logic drives the master side.
    modport slave (
        input  IF_PC, IF_Inst, EX_MemRead, EX_Rt, EX_BranchTaken, ID_Jump, IRQ,
        output ID_PC, ID_Inst, ID_Valid, stall, EX_Bubble, IRQ_Take, ID_EPC
    );

    modport master (
        output IF_PC, IF_Inst, EX_MemRead, EX_Rt, EX_BranchTaken, ID_Jump, IRQ,
        input  ID_PC, ID_Inst, ID_Valid, stall, EX_Bubble, IRQ_Take, ID_EPC
    );
endinterface

// File: rtl/pipeline_ifid.sv
// IF/ID pipeline register with load-use stall, branch/jump squash and precise interrupt take.
// Define PIPELINE_IFID_IRQ_EN to enable interrupt acceptance; otherwise IRQ is ignored.
module pipeline_ifid (
    input logic             clk,
    input logic             reset,
    pipeline_ifid_if.slave  bus
);
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        stall;
    logic        irq_take;

    // Load-use hazard: the load in EX writes a register the ID instruction reads; $0 never hazards.
    assign stall = id_valid & bus.EX_MemRead & (bus.EX_Rt != 5'd0) &
                   ((bus.EX_Rt == id_inst[25:21]) | (bus.EX_Rt == id_inst[20:16]));

`ifdef PIPELINE_IFID_IRQ_EN
    logic irq_pending;

    // Only user-mode (ID_PC[31]=0) instructions may be replaced, and never while held or flushed.
    assign irq_take = irq_pending & id_valid & ~id_pc[31] & ~stall & ~bus.EX_BranchTaken;

    // A new request on the same edge as a take re-arms pending, so set dominates clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pending <= 1'b0;
        end else if (bus.IRQ) begin
            irq_pending <= 1'b1;
        end else if (irq_take) begin
            irq_pending <= 1'b0;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = bus.IRQ;
    assign irq_take   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            id_pc    <= 32'd0;
            id_inst  <= 32'd0;
            id_valid <= 1'b0;
        end else if (bus.EX_BranchTaken) begin
            id_pc    <= bus.IF_PC;
            id_inst  <= 32'd0;
            id_valid <= 1'b0;
        end else if (irq_take) begin
            id_inst  <= 32'd0;
            id_valid <= 1'b0;
        end else if (stall) begin
            id_pc    <= id_pc;
            id_inst  <= id_inst;
            id_valid <= id_valid;
        end else if (bus.ID_Jump) begin
            id_inst  <= 32'd0;
            id_valid <= 1'b0;
        end else begin
            id_pc    <= bus.IF_PC;
            id_inst  <= bus.IF_Inst;
            id_valid <= 1'b1;
        end
    end

    assign bus.ID_PC     = id_pc;
    assign bus.ID_Inst   = id_inst;
    assign bus.ID_Valid  = id_valid;
    assign bus.stall     = stall;
    assign bus.IRQ_Take  = irq_take;
    assign bus.EX_Bubble = stall | irq_take | bus.EX_BranchTaken;
    assign bus.ID_EPC    = id_pc - 32'd4;
endmodule

// File: tb/tb_pipeline_ifid.sv
// Directed testbench for pipeline_ifid; interrupt scenarios follow PIPELINE_IFID_IRQ_EN.
module tb_pipeline_ifid;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pipeline_ifid_if bus ();

    pipeline_ifid dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 ns past it before any sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.IF_PC   = 32'h0000_0044;
        bus.IF_Inst = 32'hDEAD_BEEF;
        tick();
        tick();
        checks++; if (bus.ID_PC !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_pc got=%h exp=%h", bus.ID_PC, 32'h0); end
        checks++; if (bus.ID_Inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_inst got=%h exp=%h", bus.ID_Inst, 32'h0); end
        checks++; if (bus.ID_Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid got=%b exp=0", bus.ID_Valid); end
        checks++; if (bus.stall !== 1'b0 || bus.EX_Bubble !== 1'b0 || bus.IRQ_Take !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_comb got stall=%b bubble=%b take=%b exp all 0", bus.stall, bus.EX_Bubble, bus.IRQ_Take);
        end
        checks++; if (bus.ID_EPC !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL reset_epc got=%h exp=%h", bus.ID_EPC, 32'hFFFF_FFFC); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        for (int i = 0; i < 3; i++) begin
            exp_pc      = 32'd4 * (i + 1);
            exp_inst    = 32'h2008_0001 + i;
            bus.IF_PC   = exp_pc;
            bus.IF_Inst = exp_inst;
            tick();
            checks++; if (bus.ID_PC !== exp_pc) begin errors++; $display("[TB] FAIL seq_pc[%0d] got=%h exp=%h", i, bus.ID_PC, exp_pc); end
            checks++; if (bus.ID_Inst !== exp_inst) begin errors++; $display("[TB] FAIL seq_inst[%0d] got=%h exp=%h", i, bus.ID_Inst, exp_inst); end
            checks++; if (bus.ID_Valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid[%0d] got=%b exp=1", i, bus.ID_Valid); end
            checks++; if (bus.ID_EPC !== exp_pc - 32'd4) begin errors++; $display("[TB] FAIL seq_epc[%0d] got=%h exp=%h", i, bus.ID_EPC, exp_pc - 32'd4); end
        end
    endtask

    task automatic test_load_use();
        // add $9,$8,$10 enters ID
        bus.IF_PC   = 32'h0000_0100;
        bus.IF_Inst = 32'h010A_4820;
        tick();
        bus.EX_MemRead = 1'b1;
        bus.EX_Rt      = 5'd8;
        bus.IF_PC      = 32'h0000_0104;
        bus.IF_Inst    = 32'h0000_4820;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall got=%b exp=1", bus.stall); end
        checks++; if (bus.EX_Bubble !== 1'b1) begin errors++; $display("[TB] FAIL lu_bubble got=%b exp=1", bus.EX_Bubble); end
        tick();
        checks++; if (bus.ID_PC !== 32'h100 || bus.ID_Inst !== 32'h010A_4820) begin
            errors++; $display("[TB] FAIL lu_hold got pc=%h inst=%h exp pc=%h inst=%h", bus.ID_PC, bus.ID_Inst, 32'h100, 32'h010A_4820);
        end
        bus.EX_MemRead = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.EX_Bubble !== 1'b0) begin errors++; $display("[TB] FAIL lu_release got stall=%b bubble=%b exp 0/0", bus.stall, bus.EX_Bubble); end
        tick();
        checks++; if (bus.ID_PC !== 32'h104 || bus.ID_Inst !== 32'h0000_4820) begin
            errors++; $display("[TB] FAIL lu_advance got pc=%h inst=%h exp pc=%h inst=%h", bus.ID_PC, bus.ID_Inst, 32'h104, 32'h0000_4820);
        end
        // Load into $0 never hazards even though rs/rt of ID are $0
        bus.EX_MemRead = 1'b1;
        bus.EX_Rt      = 5'd0;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.EX_Bubble !== 1'b0) begin errors++; $display("[TB] FAIL lu_rt0 got stall=%b bubble=%b exp 0/0", bus.stall, bus.EX_Bubble); end
        bus.EX_MemRead = 1'b0;
    endtask

    task automatic test_branch();
        bus.IF_PC   = 32'h0000_0200;
        bus.IF_Inst = 32'h010A_4820;
        tick();
        // Match via the rt field ($10)
        bus.EX_MemRead = 1'b1;
        bus.EX_Rt      = 5'd10;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL br_rt_stall got=%b exp=1", bus.stall); end
        bus.EX_BranchTaken = 1'b1;
        bus.IF_PC          = 32'h0000_0300;
        bus.IF_Inst        = 32'h1234_5678;
        #1;
        checks++; if (bus.EX_Bubble !== 1'b1) begin errors++; $display("[TB] FAIL br_bubble got=%b exp=1", bus.EX_Bubble); end
        tick();
        bus.EX_BranchTaken = 1'b0;
        #1;
        checks++; if (bus.ID_Inst !== 32'h0 || bus.ID_Valid !== 1'b0) begin errors++; $display("[TB] FAIL br_flush got inst=%h valid=%b exp 0/0", bus.ID_Inst, bus.ID_Valid); end
        checks++; if (bus.ID_PC !== 32'h300) begin errors++; $display("[TB] FAIL br_pc got=%h exp=%h", bus.ID_PC, 32'h300); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL br_nostall got=%b exp=0", bus.stall); end
        bus.EX_MemRead = 1'b0;
    endtask

    task automatic test_jump();
        bus.IF_PC   = 32'h0000_0400;
        bus.IF_Inst = 32'h0800_0040;
        tick();
        bus.ID_Jump = 1'b1;
        bus.IF_PC   = 32'h0000_0404;
        bus.IF_Inst = 32'h1234_5678;
        tick();
        bus.ID_Jump = 1'b0;
        checks++; if (bus.ID_Inst !== 32'h0 || bus.ID_Valid !== 1'b0) begin errors++; $display("[TB] FAIL jmp_flush got inst=%h valid=%b exp 0/0", bus.ID_Inst, bus.ID_Valid); end
        // Jump during a stall: hold wins, flush happens once the stall clears
        bus.IF_PC   = 32'h0000_0500;
        bus.IF_Inst = 32'h010A_4820;
        tick();
        bus.EX_MemRead = 1'b1;
        bus.EX_Rt      = 5'd8;
        bus.ID_Jump    = 1'b1;
        bus.IF_Inst    = 32'h1234_5678;
        tick();
        checks++; if (bus.ID_Inst !== 32'h010A_4820 || bus.ID_Valid !== 1'b1) begin
            errors++; $display("[TB] FAIL jmp_stall_hold got inst=%h valid=%b exp inst=%h valid=1", bus.ID_Inst, bus.ID_Valid, 32'h010A_4820);
        end
        bus.EX_MemRead = 1'b0;
        tick();
        bus.ID_Jump = 1'b0;
        checks++; if (bus.ID_Inst !== 32'h0 || bus.ID_Valid !== 1'b0) begin errors++; $display("[TB] FAIL jmp_deferred got inst=%h valid=%b exp 0/0", bus.ID_Inst, bus.ID_Valid); end
    endtask

    task automatic test_branch_and_jump();
        bus.IF_PC   = 32'h0000_0600;
        bus.IF_Inst = 32'h2008_0001;
        tick();
        bus.EX_BranchTaken = 1'b1;
        bus.ID_Jump        = 1'b1;
        bus.IF_PC          = 32'h0000_0700;
        tick();
        bus.EX_BranchTaken = 1'b0;
        bus.ID_Jump        = 1'b0;
        checks++; if (bus.ID_PC !== 32'h700 || bus.ID_Valid !== 1'b0) begin errors++; $display("[TB] FAIL brj_prio got pc=%h valid=%b exp pc=%h valid=0", bus.ID_PC, bus.ID_Valid, 32'h700); end
    endtask

`ifdef PIPELINE_IFID_IRQ_EN
    task automatic test_irq();
        bus.IF_PC   = 32'h0000_0010;
        bus.IF_Inst = 32'h2008_0001;
        bus.IRQ     = 1'b1;
        tick();
        bus.IRQ = 1'b0;
        checks++; if (bus.IRQ_Take !== 1'b1) begin errors++; $display("[TB] FAIL irq_take got=%b exp=1", bus.IRQ_Take); end
        checks++; if (bus.ID_EPC !== 32'h0000_000C) begin errors++; $display("[TB] FAIL irq_epc got=%h exp=%h", bus.ID_EPC, 32'hC); end
        checks++; if (bus.EX_Bubble !== 1'b1) begin errors++; $display("[TB] FAIL irq_bubble got=%b exp=1", bus.EX_Bubble); end
        bus.IF_PC = 32'h0000_0014;
        tick();
        checks++; if (bus.ID_Valid !== 1'b0 || bus.ID_Inst !== 32'h0 || bus.IRQ_Take !== 1'b0) begin
            errors++; $display("[TB] FAIL irq_squash got valid=%b inst=%h take=%b exp 0/0/0", bus.ID_Valid, bus.ID_Inst, bus.IRQ_Take);
        end
        bus.IF_PC = 32'h0000_0018;
        tick();
        checks++; if (bus.IRQ_Take !== 1'b0 || bus.ID_Valid !== 1'b1) begin errors++; $display("[TB] FAIL irq_cleared got take=%b valid=%b exp 0/1", bus.IRQ_Take, bus.ID_Valid); end
        // Kernel-mode instructions are never replaced; pending waits for user mode
        bus.IF_PC = 32'h8000_0010;
        bus.IRQ   = 1'b1;
        tick();
        bus.IRQ = 1'b0;
        checks++; if (bus.IRQ_Take !== 1'b0) begin errors++; $display("[TB] FAIL irq_kernel0 got=%b exp=0", bus.IRQ_Take); end
        bus.IF_PC = 32'h8000_0014;
        tick();
        checks++; if (bus.IRQ_Take !== 1'b0) begin errors++; $display("[TB] FAIL irq_kernel1 got=%b exp=0", bus.IRQ_Take); end
        bus.IF_PC = 32'h0000_0020;
        tick();
        checks++; if (bus.IRQ_Take !== 1'b1 || bus.ID_EPC !== 32'h0000_001C) begin
            errors++; $display("[TB] FAIL irq_user_take got take=%b epc=%h exp take=1 epc=%h", bus.IRQ_Take, bus.ID_EPC, 32'h1C);
        end
        bus.IF_PC = 32'h0000_0024;
        tick();
        // Reset and IRQ on the same edge: pending must stay clear
        reset   = 1'b1;
        bus.IRQ = 1'b1;
        tick();
        reset     = 1'b0;
        bus.IRQ   = 1'b0;
        bus.IF_PC = 32'h0000_0030;
        tick();
        checks++; if (bus.IRQ_Take !== 1'b0 || bus.ID_Valid !== 1'b1) begin errors++; $display("[TB] FAIL irq_reset got take=%b valid=%b exp 0/1", bus.IRQ_Take, bus.ID_Valid); end
    endtask
`else
    task automatic test_irq();
        bus.IF_PC   = 32'h0000_0010;
        bus.IF_Inst = 32'h2008_0001;
        bus.IRQ     = 1'b1;
        tick();
        bus.IRQ = 1'b0;
        checks++; if (bus.IRQ_Take !== 1'b0) begin errors++; $display("[TB] FAIL irqdis_take0 got=%b exp=0", bus.IRQ_Take); end
        bus.IF_PC = 32'h0000_0014;
        tick();
        checks++; if (bus.IRQ_Take !== 1'b0 || bus.ID_Valid !== 1'b1 || bus.ID_PC !== 32'h14) begin
            errors++; $display("[TB] FAIL irqdis_flow got take=%b valid=%b pc=%h exp 0/1/%h", bus.IRQ_Take, bus.ID_Valid, bus.ID_PC, 32'h14);
        end
        checks++; if (bus.ID_EPC !== 32'h0000_0010) begin errors++; $display("[TB] FAIL irqdis_epc got=%h exp=%h", bus.ID_EPC, 32'h10); end
    endtask
`endif

    initial begin
        errors             = 0;
        checks             = 0;
        reset              = 1'b1;
        bus.IF_PC          = 32'h0;
        bus.IF_Inst        = 32'h0;
        bus.EX_MemRead     = 1'b0;
        bus.EX_Rt          = 5'd0;
        bus.EX_BranchTaken = 1'b0;
        bus.ID_Jump        = 1'b0;
        bus.IRQ            = 1'b0;
        test_reset();
        test_sequential();
        test_load_use();
        test_branch();
        test_jump();
        test_branch_and_jump();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
